// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the integer writeback port arbiter.
// Register file geometry and writeback requester indices.
package wb_port_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN_DEF   = 32;

  localparam int WB_ALU     = 0;
  localparam int WB_LSU     = 1;
  localparam int WB_MULDIV  = 2;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctl_t;

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant.
// Produces a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Integer RF write-port arbiter with registered write stage
// and in-flight destination scoreboard for decode hazards.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*5-1:0]       req_rd_i,
  input  logic [NUM_REQ*XLEN-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [REG_ADDR_W-1:0]      rf_rd_o,
  output logic [XLEN-1:0]            rf_write_data_o,
  output logic                       rf_reg_write_o,
  input  logic                       issue_valid_i,
  input  logic [REG_ADDR_W-1:0]      issue_rd_i,
  input  logic [REG_ADDR_W-1:0]      rs1_i,
  input  logic [REG_ADDR_W-1:0]      rs2_i,
  output logic                       stall_o,
  output logic [NUM_REGS-1:0]        busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic [NUM_REQ-1:0]    gnt;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  wb_ctl_t               ctl_q, ctl_d;
  logic [XLEN-1:0]       data_q, data_d;

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [NUM_REGS-1:0]   set_vec, clr_vec;
  logic                  stall;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready_o = gnt;
  assign sel_rd      = req_rd_i[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign sel_data    = req_data_i[int'(gnt_idx)*XLEN +: XLEN];

  // x0 writebacks take the slot but never assert the write enable
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    ctl_d.we = 1'b0;
    ctl_d.rd = ctl_q.rd;
    data_d   = data_q;
    if (gnt_any) begin
      rr_ptr_d = gnt_idx;
      ctl_d.we = (sel_rd != '0);
      ctl_d.rd = sel_rd;
      data_d   = sel_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      ctl_q    <= '0;
      data_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ctl_q    <= ctl_d;
      data_q   <= data_d;
    end
  end

  assign rf_reg_write_o  = ctl_q.we;
  assign rf_rd_o         = ctl_q.rd;
  assign rf_write_data_o = data_q;

  assign stall = busy_q[rs1_i] | busy_q[rs2_i]
               | (issue_valid_i & busy_q[issue_rd_i]);

  // Clear lands on the RF commit edge; a new set wins over it
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid_i && !stall) set_vec[issue_rd_i] = 1'b1;
    if (ctl_q.we) clr_vec[ctl_q.rd] = 1'b1;
    busy_d    = set_vec | (busy_q & ~clr_vec);
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign stall_o = stall;
  assign busy_o  = busy_q;

endmodule
